// File: rtl/wb_shared_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_shared_arb_if
//  Description : Wishbone bundle between the two CPU masters (data port m0,
//                instruction port m1), the shared-BRAM arbiter and the BRAM
//                slave.
//  Modports    : slave  - arbiter view: serves the masters as their slave
//                         and drives the shared BRAM request.
//                master - environment view: drives the master requests and
//                         the BRAM response, observes everything else.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_shared_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // master 0 (CPU data port)
    logic [DW-1:0] m0_data_i;
    logic [AW-1:0] m0_addr_i;
    logic [3:0]    m0_sel_i;
    logic          m0_we_i;
    logic          m0_cyc_i;
    logic          m0_stb_i;
    logic [DW-1:0] m0_data_o;
    logic          m0_ack_o;
    logic          m0_err_o;

    // master 1 (CPU instruction port)
    logic [DW-1:0] m1_data_i;
    logic [AW-1:0] m1_addr_i;
    logic [3:0]    m1_sel_i;
    logic          m1_we_i;
    logic          m1_cyc_i;
    logic          m1_stb_i;
    logic [DW-1:0] m1_data_o;
    logic          m1_ack_o;
    logic          m1_err_o;

    // shared BRAM slave
    logic [DW-1:0] s_data_o;
    logic [AW-1:0] s_addr_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o;
    logic          s_cyc_o;
    logic          s_stb_o;
    logic [DW-1:0] s_data_i;
    logic          s_ack_i;
    logic          s_err_i;

    modport slave (
        input  m0_data_i, m0_addr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        output m0_data_o, m0_ack_o, m0_err_o,
        input  m1_data_i, m1_addr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        output m1_data_o, m1_ack_o, m1_err_o,
        output s_data_o, s_addr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_data_i, s_ack_i, s_err_i
    );

    modport master (
        output m0_data_i, m0_addr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        input  m0_data_o, m0_ack_o, m0_err_o,
        output m1_data_i, m1_addr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        input  m1_data_o, m1_ack_o, m1_err_o,
        input  s_data_o, s_addr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_data_i, s_ack_i, s_err_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_shared_arb.sv
`default_nettype none
// ============================================================================
//  Module      : wb_shared_arb
//  Description : Two-master round-robin Wishbone arbiter in front of a single
//                shared BRAM slave, with a no-acknowledge watchdog that
//                aborts a stalled transfer with an error response.
//  Ports       : clk_i     - system clock, rising edge
//                rst_i     - asynchronous active-low reset
//                bus       - wb_shared_arb_if.slave (masters + BRAM slave)
//                grant_o   - one-hot owner: 01 = m0, 10 = m1, 00 = none
//                timeout_o - one-cycle pulse on a watchdog abort
//  Parameters  : AW, DW    - Wishbone address / data width
//                TIMEOUT   - wait-cycle limit before abort (1..255)
//  Revision    : 1.0  initial release
// ============================================================================
module wb_shared_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    wb_shared_arb_if.slave  bus,
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    localparam logic [7:0] c_TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [7:0] c_CNT_MAX     = 8'hFF;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_last_m1;     // 1: m1 was the most recent owner
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_next;
    logic          w_timeout;

    // request of whichever master currently owns the slave
    logic          w_own_cyc;
    logic          w_own_stb;
    logic          w_own_we;
    logic [3:0]    w_own_sel;
    logic [AW-1:0] w_own_addr;
    logic [DW-1:0] w_own_data;

    // ------------------------------------------------------------------
    // Owner request multiplexer (all-zero while idle)
    // ------------------------------------------------------------------
    always_comb begin
        w_own_cyc  = 1'b0;
        w_own_stb  = 1'b0;
        w_own_we   = 1'b0;
        w_own_sel  = '0;
        w_own_addr = '0;
        w_own_data = '0;
        case (r_state)
            c_OWN0: begin
                w_own_cyc  = bus.m0_cyc_i;
                w_own_stb  = bus.m0_stb_i;
                w_own_we   = bus.m0_we_i;
                w_own_sel  = bus.m0_sel_i;
                w_own_addr = bus.m0_addr_i;
                w_own_data = bus.m0_data_i;
            end
            c_OWN1: begin
                w_own_cyc  = bus.m1_cyc_i;
                w_own_stb  = bus.m1_stb_i;
                w_own_we   = bus.m1_we_i;
                w_own_sel  = bus.m1_sel_i;
                w_own_addr = bus.m1_addr_i;
                w_own_data = bus.m1_data_i;
            end
            default: ;
        endcase
    end

    // An acknowledge or error in the limit cycle wins over the watchdog.
    assign w_timeout = (r_state != c_IDLE) && (r_cnt == c_TIMEOUT_CNT) &&
                       !bus.s_ack_i && !bus.s_err_i;

    // ------------------------------------------------------------------
    // Wait counter: counts owner strobe cycles without a slave response
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next = r_cnt;
        if ((r_state == c_IDLE) || bus.s_ack_i || bus.s_err_i || !w_own_stb) begin
            w_cnt_next = 8'd0;
        end else if (r_cnt != c_CNT_MAX) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // State register (with last-owner bit and wait counter)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= c_IDLE;
            r_last_m1 <= 1'b1;       // m0 wins the first tie after reset
            r_cnt     <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            // A timed-out owner stays recorded, so the other master wins
            // the next tie.
            if ((r_state == c_IDLE) && (w_next_state != c_IDLE)) begin
                r_last_m1 <= (w_next_state == c_OWN1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    w_next_state = r_last_m1 ? c_OWN0 : c_OWN1;
                end else if (bus.m0_cyc_i) begin
                    w_next_state = c_OWN0;
                end else if (bus.m1_cyc_i) begin
                    w_next_state = c_OWN1;
                end else begin
                    w_next_state = c_IDLE;
                end
            end
            c_OWN0: begin
                if (w_timeout || !bus.m0_cyc_i) begin
                    w_next_state = c_IDLE;
                end
            end
            c_OWN1: begin
                if (w_timeout || !bus.m1_cyc_i) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        grant_o   = {r_state == c_OWN1, r_state == c_OWN0};
        timeout_o = w_timeout;

        // the watchdog abort withdraws the cycle in the cycle it fires
        bus.s_cyc_o  = w_own_cyc & ~w_timeout;
        bus.s_stb_o  = w_own_stb & ~w_timeout;
        bus.s_we_o   = w_own_we;
        bus.s_sel_o  = w_own_sel;
        bus.s_addr_o = w_own_addr;
        bus.s_data_o = w_own_data;

        bus.m0_data_o = bus.s_data_i;
        bus.m1_data_o = bus.s_data_i;

        bus.m0_ack_o = (r_state == c_OWN0) & bus.s_ack_i;
        bus.m0_err_o = (r_state == c_OWN0) & (bus.s_err_i | w_timeout);
        bus.m1_ack_o = (r_state == c_OWN1) & bus.s_ack_i;
        bus.m1_err_o = (r_state == c_OWN1) & (bus.s_err_i | w_timeout);
    end

endmodule
`default_nettype wire
